clock_set_ctrl: RTL and testbench

Mode/sequence controller for the 24h BCD clock chain. Owns the one-second tick that drives the seconds stage, and handles run/pause. Runs the hour/minute set sequence and commits the edited time to the clock chain as a one-cycle load strobe with the new BCD value. Sits between the front-panel buttons, the 24h counter chain and the 7-segment display driver (blink mask).

---
 rtl/clock_set_ctrl.sv | 124 ++++++++++++
 tb/tb_clock_set_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: run/pause/set sequencer, second tick and commit strobe for the 24h BCD clock chain
module clock_set_ctrl #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int BLINK_DIV = TICK_DIV / 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic        btn_start,
    input  logic [23:0] cur_digit,
    output logic        sec_en,
    output logic        load,
    output logic [23:0] load_digit,
    output logic [1:0]  state,
    output logic [5:0]  blink_mask
);
    typedef enum logic [1:0] {RUN, PAUSE, SET_HOUR, SET_MIN} state_t;
    localparam int CW = $clog2(TICK_DIV);
    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_DIV - 1);
    state_t        st;
    logic [CW-1:0] cnt;
    logic [BW-1:0] bcnt;
    logic          phase;
    logic [7:0]    edit_hh, edit_mm, snap_hh, snap_mm, hh_inc, mm_inc;
    logic [2:0]    btn, s0, s1, s2, armed, rise;
    logic [1:0]    settle;
    logic          mode_e, inc_e, start_e, blk_wrap, phase_nx, ss_unused;
    assign btn = {btn_start, btn_inc, btn_mode};
    assign ss_unused = ^cur_digit[7:0];
    // a button counts as armed only once it has been seen released after reset
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            s0     <= '0;
            s1     <= '0;
            s2     <= '0;
            armed  <= '0;
            settle <= '0;
        end else begin
            s0     <= btn;
            s1     <= s0;
            s2     <= s1;
            settle <= settle == 2'd2 ? settle : settle + 2'd1;
            armed  <= armed | (~s1 & {3{settle == 2'd2}});
        end
    assign rise    = s1 & ~s2 & armed;
    assign mode_e  = rise[0];
    assign inc_e   = rise[1];
    assign start_e = rise[2];
    assign snap_hh = (cur_digit[23:20] <= 4'd2 && cur_digit[19:16] <= 4'd9 && cur_digit[23:16] <= 8'h23) ? cur_digit[23:16] : 8'h00;
    assign snap_mm = (cur_digit[15:12] <= 4'd5 && cur_digit[11:8] <= 4'd9) ? cur_digit[15:8] : 8'h00;
    assign hh_inc  = edit_hh == 8'h23 ? 8'h00 : edit_hh[3:0] == 4'd9 ? {edit_hh[7:4] + 4'd1, 4'd0} : edit_hh + 8'd1;
    assign mm_inc  = edit_mm == 8'h59 ? 8'h00 : edit_mm[3:0] == 4'd9 ? {edit_mm[7:4] + 4'd1, 4'd0} : edit_mm + 8'd1;
    assign blk_wrap = bcnt == BLK_MAX;
    assign phase_nx = phase ^ blk_wrap;
    assign state    = st;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            st         <= RUN;
            cnt        <= '0;
            bcnt       <= '0;
            phase      <= 1'b0;
            edit_hh    <= '0;
            edit_mm    <= '0;
            sec_en     <= 1'b0;
            load       <= 1'b0;
            load_digit <= '0;
            blink_mask <= '0;
        end else begin
            sec_en <= 1'b0;
            load   <= 1'b0;
            case (st)
                RUN, PAUSE: begin
                    if (st == RUN) begin
                        cnt    <= cnt == CNT_MAX ? '0 : cnt + CW'(1);
                        sec_en <= cnt == CNT_MAX;
                    end
                    blink_mask <= '0;
                    if (mode_e) begin
                        st         <= SET_HOUR;
                        cnt        <= '0;
                        edit_hh    <= snap_hh;
                        edit_mm    <= snap_mm;
                        bcnt       <= '0;
                        phase      <= 1'b1;
                        blink_mask <= 6'b110000;
                    end else if (start_e)
                        st <= st == RUN ? PAUSE : RUN;
                end
                SET_HOUR: begin
                    load_digit <= {edit_hh, edit_mm, 8'h00};
                    if (mode_e) begin
                        st         <= SET_MIN;
                        bcnt       <= '0;
                        phase      <= 1'b1;
                        blink_mask <= 6'b001100;
                    end else begin
                        if (inc_e) edit_hh <= hh_inc;
                        bcnt       <= blk_wrap ? '0 : bcnt + BW'(1);
                        phase      <= phase_nx;
                        blink_mask <= phase_nx ? 6'b110000 : 6'b000000;
                    end
                end
                SET_MIN: begin
                    load_digit <= {edit_hh, edit_mm, 8'h00};
                    if (mode_e) begin
                        st         <= RUN;
                        load       <= 1'b1;
                        cnt        <= '0;
                        bcnt       <= '0;
                        phase      <= 1'b0;
                        blink_mask <= '0;
                    end else begin
                        if (inc_e) edit_mm <= mm_inc;
                        bcnt       <= blk_wrap ? '0 : bcnt + BW'(1);
                        phase      <= phase_nx;
                        blink_mask <= phase_nx ? 6'b001100 : 6'b000000;
                    end
                end
            endcase
        end
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed and random stimulus against a behavioural clock-controller model
module tb_clock_set_ctrl;
    localparam int TICK  = 10;
    localparam int BLINK = 5;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        btn_mode, btn_inc, btn_start;
    logic [23:0] cur_digit;
    logic        sec_en, load;
    logic [23:0] load_digit;
    logic [1:0]  state;
    logic [5:0]  blink_mask;
    int          n_chk = 0;
    int          n_err = 0;
    string       ph;
    int          n, m_state, m_cnt, m_hh, m_mm, m_bk;
    logic        m_sec, m_load;
    logic [23:0] m_ld;
    logic [5:0]  m_mask;
    logic [3:0]  hm, hi, hs;

    clock_set_ctrl #(.TICK_DIV(TICK), .BLINK_DIV(BLINK)) dut (
        .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .btn_start(btn_start), .cur_digit(cur_digit), .sec_en(sec_en),
        .load(load), .load_digit(load_digit), .state(state), .blink_mask(blink_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int snap(input logic [7:0] b, input int lim);
        int v;
        v = int'(b[7:4]) * 10 + int'(b[3:0]);
        return (b[7:4] <= 4'd9 && b[3:0] <= 4'd9 && v <= lim) ? v : 0;
    endfunction

    task automatic model_reset();
        n = 0; m_state = 0; m_cnt = 0; m_hh = 0; m_mm = 0; m_bk = 0;
        m_sec = 0; m_load = 0; m_ld = '0; m_mask = '0;
        hm = '0; hi = '0; hs = '0;
    endtask

    // a press acts at the third sampled edge after a low-to-high change seen after reset
    task automatic model_step();
        bit em, ei, es;
        n++;
        hm = {hm[2:0], btn_mode};
        hi = {hi[2:0], btn_inc};
        hs = {hs[2:0], btn_start};
        em = n >= 4 && hm[2] && !hm[3];
        ei = n >= 4 && hi[2] && !hi[3];
        es = n >= 4 && hs[2] && !hs[3];
        m_sec = 0;
        m_load = 0;
        if (m_state >= 2) m_ld = {to_bcd(m_hh), to_bcd(m_mm), 8'h00};
        case (m_state)
            0, 1: begin
                if (m_state == 0) begin
                    m_sec = m_cnt == TICK - 1;
                    m_cnt = (m_cnt + 1) % TICK;
                end
                if (em) begin
                    m_hh = snap(cur_digit[23:16], 23);
                    m_mm = snap(cur_digit[15:8], 59);
                    m_cnt = 0;
                    m_state = 2;
                    m_bk = 0;
                end else if (es) m_state = 1 - m_state;
            end
            2: if (em) begin m_state = 3; m_bk = 0; end
               else begin if (ei) m_hh = (m_hh + 1) % 24; m_bk++; end
            default: if (em) begin m_load = 1; m_state = 0; m_cnt = 0; end
               else begin if (ei) m_mm = (m_mm + 1) % 60; m_bk++; end
        endcase
        m_mask = ((m_bk / BLINK) % 2 != 0) ? 6'b000000 : m_state == 2 ? 6'b110000 : m_state == 3 ? 6'b001100 : 6'b000000;
    endtask

    task automatic check_outs();
        check({ph, ":sec_en"}, 32'(sec_en), 32'(m_sec));
        check({ph, ":load"}, 32'(load), 32'(m_load));
        check({ph, ":load_digit"}, 32'(load_digit), 32'(m_ld));
        check({ph, ":state"}, 32'(state), 32'(m_state));
        check({ph, ":blink_mask"}, 32'(blink_mask), 32'(m_mask));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_outs();
    endtask

    task automatic press(input bit m, input bit i, input bit s, input int hold);
        if (m) btn_mode = 1;
        if (i) btn_inc = 1;
        if (s) btn_start = 1;
        repeat (hold) tick();
        if (m) btn_mode = 0;
        if (i) btn_inc = 0;
        if (s) btn_start = 0;
        repeat (hold) tick();
    endtask

    initial begin
        ph = "reset";
        rst_n = 0; btn_mode = 0; btn_inc = 0; btn_start = 0; cur_digit = '0;
        model_reset();
        #12;
        check_outs();
        @(negedge clk) rst_n = 1;

        ph = "run";
        repeat (25) tick();
        press(0, 0, 1, 4);
        repeat (30) tick();
        press(0, 0, 1, 4);
        repeat (25) tick();

        ph = "set_wrap";
        cur_digit = 24'h235930;
        press(1, 0, 0, 4);
        press(0, 1, 0, 4);
        press(1, 0, 0, 4);
        repeat (3) press(0, 1, 0, 4);
        press(1, 0, 0, 4);
        repeat (15) tick();

        ph = "invalid";
        cur_digit = 24'h2A7705;
        press(1, 0, 0, 4);
        repeat (10) press(0, 1, 0, 4);
        check("invalid:hh10", 32'(load_digit[23:16]), 32'h10);
        press(1, 0, 0, 4);
        press(1, 0, 0, 4);
        repeat (12) tick();

        ph = "simul";
        cur_digit = 24'h084512;
        press(1, 0, 0, 4);
        press(0, 1, 0, 4);
        press(1, 1, 0, 4);
        check("simul:in_set_min", 32'(state), 32'd3);
        press(0, 0, 1, 4);
        check("simul:start_ignored", 32'(state), 32'd3);

        ph = "blink";
        press(1, 0, 0, 4);
        press(1, 0, 0, 4);
        repeat (30) tick();
        press(1, 0, 0, 4);
        repeat (20) tick();

        ph = "areset";
        #3 rst_n = 0;
        model_reset();
        #1;
        check_outs();
        btn_mode = 1;
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (10) tick();
        btn_mode = 0;
        repeat (5) tick();
        press(1, 0, 0, 4);
        repeat (10) tick();
        press(1, 0, 0, 4);
        press(1, 0, 0, 4);
        repeat (12) tick();

        ph = "random";
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0)
                cur_digit = $urandom_range(0, 1) ? {to_bcd($urandom_range(0, 23)), to_bcd($urandom_range(0, 59)), to_bcd($urandom_range(0, 59))}
                                                 : 24'($urandom());
            if ($urandom_range(0, 7) == 0) btn_mode = ~btn_mode;
            if ($urandom_range(0, 5) == 0) btn_inc = ~btn_inc;
            if ($urandom_range(0, 9) == 0) btn_start = ~btn_start;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
